// File: rtl/dct_in_arb.sv
// Two-source round-robin arbiter feeding the DCT row collector.
// A grant covers a whole BURST-byte block, so rows and blocks are never interleaved between sources.
module dct_in_arb #(
  parameter int BURST = 64,
  parameter int CNTW  = 7
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       STB0,
  input  logic [7:0] DAT0,
  output logic       ACK0,
  input  logic       STB1,
  input  logic [7:0] DAT1,
  output logic       ACK1,
  output logic       STBo,
  output logic [7:0] DATo,
  input  logic       ACKo,
  output logic       SRC,
  output logic       BUSY,
  output logic       BLK_DONE
);

  // state | meaning
  // IDLE  | no grant; arbitrate between requesting sources
  // GRANT | SRC owns the collector port until BURST bytes have transferred
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BURST - 1);

  logic [0:0]      state;
  logic            last;
  logic [CNTW-1:0] cnt;
  logic            busy;
  logic            own_stb;
  logic            win;
  logic            xfer;
  logic            last_byte;

  // On a tie the source not served most recently wins.
  always_comb begin
    busy    = (state == GRANT);
    own_stb = SRC ? STB1 : STB0;
    win     = (STB0 & STB1) ? ~last : STB1;
  end

  // DATo follows the registered SRC even in IDLE so it never carries X.
  assign STBo      = busy & own_stb;
  assign DATo      = SRC ? DAT1 : DAT0;
  assign ACK0      = busy & ~SRC & ACKo;
  assign ACK1      = busy & SRC & ACKo;
  assign BUSY      = busy;
  assign xfer      = STBo & ACKo;
  assign last_byte = (cnt == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      SRC      <= 1'b0;
      last     <= 1'b1;
      BLK_DONE <= 1'b0;
    end else begin
      BLK_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (STB0 | STB1) begin
            state <= GRANT;
            SRC   <= win;
            cnt   <= '0;
          end
        end
        GRANT: begin
          // The grant is held through owner gaps; only a completed burst releases it.
          if (xfer) begin
            if (last_byte) begin
              state    <= IDLE;
              cnt      <= '0;
              last     <= SRC;
              BLK_DONE <= 1'b1;
            end else begin
              cnt <= cnt + CNTW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_in_arb.sv
// Scoreboard bench for dct_in_arb: a 64-byte and an 8-byte instance run side by side,
// each against a per-cycle owner/byte-count model and a queue of expected collector bytes.
module tb_dct_in_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst, stb0, stb1, ack0, ack1, stbo, acko, src, busy, blk_done;
  logic [1:0][7:0] dat0, dat1, dato;
  logic [1:0][7:0] n0, n1;

  int   dn [2];
  int   checks   = 0;
  int   failures = 0;
  logic chk_en   = 1'b0;
  int   cyc      = 0;

  int m_busy [2];
  int m_src  [2];
  int m_last [2];
  int m_cnt  [2];
  int m_done [2];

  logic [8:0] q0[$];
  logic [8:0] q1[$];

  dct_in_arb #(.BURST(64), .CNTW(7)) dut0 (
    .CLK(clk), .RST(rst[0]),
    .STB0(stb0[0]), .DAT0(dat0[0]), .ACK0(ack0[0]),
    .STB1(stb1[0]), .DAT1(dat1[0]), .ACK1(ack1[0]),
    .STBo(stbo[0]), .DATo(dato[0]), .ACKo(acko[0]),
    .SRC(src[0]), .BUSY(busy[0]), .BLK_DONE(blk_done[0])
  );

  dct_in_arb #(.BURST(8), .CNTW(4)) dut1 (
    .CLK(clk), .RST(rst[1]),
    .STB0(stb0[1]), .DAT0(dat0[1]), .ACK0(ack0[1]),
    .STB1(stb1[1]), .DAT1(dat1[1]), .ACK1(ack1[1]),
    .STBo(stbo[1]), .DATo(dato[1]), .ACKo(acko[1]),
    .SRC(src[1]), .BUSY(busy[1]), .BLK_DONE(blk_done[1])
  );

  function automatic void chk(input string nm, input int k, input logic [8:0] act, input int exp);
    checks++;
    if (act !== 9'(exp)) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h expected=%0h t=%0t", nm, k, act, exp, $time);
    end
  endfunction

  // Reference model: who owns the port and how many bytes of the block have moved.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic int         bl      = (k == 0) ? 64 : 8;
      automatic int         s0      = int'(stb0[k]);
      automatic int         s1      = int'(stb1[k]);
      automatic int         a       = int'(acko[k]);
      automatic int         own_stb = (m_src[k] == 1) ? s1 : s0;
      automatic int         e_stbo  = (m_busy[k] != 0 && own_stb != 0) ? 1 : 0;
      automatic logic [7:0] own_dat = (m_src[k] == 1) ? dat1[k] : dat0[k];
      if (chk_en) begin
        chk("BUSY", k, 9'(busy[k]), m_busy[k]);
        chk("SRC", k, 9'(src[k]), m_src[k]);
        chk("BLK_DONE", k, 9'(blk_done[k]), m_done[k]);
        chk("STBo", k, 9'(stbo[k]), e_stbo);
        chk("ACK0", k, 9'(ack0[k]), (m_busy[k] != 0 && m_src[k] == 0) ? a : 0);
        chk("ACK1", k, 9'(ack1[k]), (m_busy[k] != 0 && m_src[k] == 1) ? a : 0);
        chk("cnt", k, (k == 0) ? 9'(dut0.cnt) : 9'(dut1.cnt), m_cnt[k]);
      end
      m_done[k] = 0;
      if (rst[k]) begin
        m_busy[k] = 0;
        m_src[k]  = 0;
        m_last[k] = 1;
        m_cnt[k]  = 0;
      end else if (m_busy[k] == 0) begin
        if (s0 != 0 || s1 != 0) begin
          m_busy[k] = 1;
          m_src[k]  = (s0 != 0 && s1 != 0) ? 1 - m_last[k] : s1;
          m_cnt[k]  = 0;
        end
      end else if (e_stbo != 0 && a != 0) begin
        if (k == 0) q0.push_back({1'(m_src[k]), own_dat});
        else        q1.push_back({1'(m_src[k]), own_dat});
        if (m_cnt[k] == bl - 1) begin
          m_busy[k] = 0;
          m_cnt[k]  = 0;
          m_last[k] = m_src[k];
          m_done[k] = 1;
        end else begin
          m_cnt[k]++;
        end
      end
    end
  end

  // Monitor: every byte the collector accepts must be the next one the model queued.
  always @(negedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (chk_en && !rst[k] && stbo[k] && acko[k]) begin
        automatic logic [8:0] got = {src[k], dato[k]};
        automatic logic [8:0] e   = '0;
        automatic int         n   = (k == 0) ? q0.size() : q1.size();
        if (n == 0) begin
          checks++;
          failures++;
          $display("FAIL DATo_unexpected inst=%0d actual=%0h expected=none t=%0t", k, got, $time);
        end else begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("DATo", k, got, int'(e));
        end
      end
    end
  end

  // One cycle: retire accepted bytes, then drive the next cycle's inputs.
  task automatic step(input int p0, input int p1, input int pa, input int prst,
                      input int lim0, input int lim1, input bit stall8);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst[k] && ack0[k] && stb0[k]) n0[k] = n0[k] + 8'd1;
      if (!rst[k] && ack1[k] && stb1[k]) n1[k] = n1[k] + 8'd1;
      dn[k] += int'(blk_done[k]);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      stb0[k] = (int'($urandom_range(99)) < p0) && (lim0 == 0 || int'(n0[k]) < lim0);
      stb1[k] = (int'($urandom_range(99)) < p1) && (lim1 == 0 || int'(n1[k]) < lim1);
      acko[k] = stall8 ? ((cyc % 8) != 7) : (int'($urandom_range(99)) < pa);
      rst[k]  = int'($urandom_range(999)) < prst;
      dat0[k] = n0[k];
      dat1[k] = n1[k];
    end
  endtask

  task automatic do_reset();
    step(0, 0, 100, 1000, 0, 0, 1'b0);
    step(0, 0, 100, 0, 0, 0, 1'b0);
    dn[0] = 0;
    dn[1] = 0;
  endtask

  initial begin
    rst  = '1;
    stb0 = '0;
    stb1 = '0;
    acko = '0;
    dat0 = '0;
    dat1 = '0;
    n0   = '0;
    n1   = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Single source 0 streams 0x00..0x3F with one collector stall every 8 cycles.
    do_reset();
    n0 = '0;
    repeat (100) step(100, 0, 100, 0, 64, 0, 1'b1);
    chk("single_done", 0, 9'(dn[0]), 1);
    chk("single_done", 1, 9'(dn[1]), 8);

    // Both sources always requesting: grants alternate, one idle cycle between bursts.
    do_reset();
    n0 = {8'hA0, 8'hA0};
    n1 = {8'hB0, 8'hB0};
    repeat (300) step(100, 100, 100, 0, 0, 0, 1'b0);
    chk("tie_done", 0, 9'(dn[0]), 4);
    chk("tie_done", 1, 9'(dn[1]), 33);

    // Source 1 alone sends 16 bytes.
    do_reset();
    n1 = '0;
    repeat (30) step(0, 100, 100, 0, 0, 16, 1'b0);
    chk("short_done", 0, 9'(dn[0]), 0);
    chk("short_done", 1, 9'(dn[1]), 2);

    // Lock: source 1 owns the port, pauses while source 0 requests.
    do_reset();
    repeat (12) step(0, 100, 100, 0, 0, 0, 1'b0);
    repeat (5) step(100, 0, 100, 0, 0, 0, 1'b0);
    repeat (80) step(100, 100, 100, 0, 0, 0, 1'b0);

    // Reset mid-burst, then both request: source 0 must win first.
    do_reset();
    repeat (31) step(100, 100, 100, 0, 0, 0, 1'b0);
    step(100, 100, 100, 1000, 0, 0, 1'b0);
    repeat (20) step(100, 100, 100, 0, 0, 0, 1'b0);

    // Owner drops its strobe the cycle the grant takes effect.
    do_reset();
    step(100, 0, 100, 0, 0, 0, 1'b0);
    repeat (4) step(0, 0, 100, 0, 0, 0, 1'b0);
    repeat (70) step(100, 0, 100, 0, 0, 0, 1'b0);

    // Random traffic with back-pressure and occasional resets.
    repeat (3000) step(70, 70, 70, 3, 0, 0, 1'b0);
    repeat (4) step(0, 0, 100, 0, 0, 0, 1'b0);

    chk("queue_empty", 0, 9'(q0.size()), 0);
    chk("queue_empty", 1, 9'(q1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
